// File: rtl/lat_pipe_pkg.sv
// Shared types and helpers for the latency-matching pipe.
package lat_pipe_pkg;

  typedef enum logic {
    LP_IDLE  = 1'b0,
    LP_DRAIN = 1'b1
  } lp_state_t;

  // Width of a latency value able to hold 0..max_delay.
  function automatic int lat_w(input int max_delay);
    return $clog2(max_delay + 1);
  endfunction

endpackage

// File: rtl/fixedp_if.sv
// Clock/reset bundle shared by fixedp datapath blocks.
interface fixedp_if (
  input logic clk,
  input logic reset_l
);

  modport pipe (input clk, input reset_l);

endinterface

// File: rtl/lat_match_lane.sv
// One lane of the latency-matching pipe: valid+data shift register with a
// runtime-selected output tap.
module lat_match_lane #(
  parameter int WIDTH     = 1,
  parameter int MAX_DELAY = 32,
  parameter int LW        = 6
) (
  input  logic             clk,
  input  logic             reset_l,
  input  logic             ce,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  input  logic [LW-1:0]    lat_cur,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             busy
);

  logic [MAX_DELAY-1:0] valid_q;
  logic [MAX_DELAY-1:0] valid_d;
  logic [WIDTH-1:0]     data_q [MAX_DELAY];
  logic [WIDTH-1:0]     data_d [MAX_DELAY];

  // Every stage shifts, including those past the tap, so a later latency
  // increase can never pick up samples left behind by an earlier setting.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (ce) begin
      valid_d[0] = in_valid;
      data_d[0]  = in_data;
      for (int s = 1; s < MAX_DELAY; s++) begin
        valid_d[s] = valid_q[s-1];
        data_d[s]  = data_q[s-1];
      end
    end
    if (flush) begin
      valid_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_l) begin
      valid_q <= '0;
    end else begin
      valid_q <= valid_d;
    end
  end

  // Data is qualified by valid, so it needs no reset.
  always_ff @(posedge clk) begin
    data_q <= data_d;
  end

  always_comb begin
    out_valid = 1'b0;
    out_data  = '0;
    for (int s = 0; s < MAX_DELAY; s++) begin
      if (lat_cur == LW'(s + 1)) begin
        out_valid = valid_q[s];
        out_data  = valid_q[s] ? data_q[s] : '0;
      end
    end
  end

  assign busy = |valid_q;

endmodule

// File: rtl/lat_match_pipe.sv
// Runtime-programmable latency-matching pipe for side-band lanes that travel
// alongside a fixedp operator; holds the latency load FSM.
module lat_match_pipe
  import lat_pipe_pkg::*;
#(
  parameter int WIDTH         = 1,
  parameter int CHANNELS      = 1,
  parameter int MAX_DELAY     = 32,
  parameter int DEFAULT_DELAY = 1
) (
  fixedp_if.pipe                          g,
  input  logic                            ce,
  input  logic                            flush,
  input  logic [CHANNELS-1:0]             i_valid,
  input  logic [CHANNELS*WIDTH-1:0]       i,
  input  logic                            lat_load,
  input  logic [lat_w(MAX_DELAY)-1:0]     lat_req,
  output logic [CHANNELS-1:0]             o_valid,
  output logic [CHANNELS*WIDTH-1:0]       o,
  output logic [lat_w(MAX_DELAY)-1:0]     lat_cur,
  output logic                            lat_ack,
  output logic                            lat_err,
  output logic                            empty
);

  localparam int LW = lat_w(MAX_DELAY);

  lp_state_t       state_q, state_d;
  logic [LW-1:0]   lat_cur_q, lat_cur_d;
  logic [LW-1:0]   pend_q, pend_d;
  logic            ack_q, ack_d;
  logic            err_q, err_d;
  logic            req_legal;
  logic            in_open;
  logic [CHANNELS-1:0] lane_busy;

  assign req_legal = (lat_req != '0) && (lat_req <= LW'(MAX_DELAY));
  // While draining, new samples are refused so the pipe can actually empty.
  assign in_open   = (state_q == LP_IDLE);
  assign empty     = ~|lane_busy;

  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_lane
    lat_match_lane #(
      .WIDTH     (WIDTH),
      .MAX_DELAY (MAX_DELAY),
      .LW        (LW)
    ) u_lane (
      .clk       (g.clk),
      .reset_l   (g.reset_l),
      .ce        (ce),
      .flush     (flush),
      .in_valid  (i_valid[gi] & in_open),
      .in_data   (i[gi*WIDTH +: WIDTH]),
      .lat_cur   (lat_cur_q),
      .out_valid (o_valid[gi]),
      .out_data  (o[gi*WIDTH +: WIDTH]),
      .busy      (lane_busy[gi])
    );
  end

  always_comb begin
    state_d   = state_q;
    lat_cur_d = lat_cur_q;
    pend_d    = pend_q;
    ack_d     = 1'b0;
    err_d     = 1'b0;
    case (state_q)
      LP_IDLE: begin
        if (lat_load) begin
          if (!req_legal) begin
            err_d = 1'b1;
          end else if (!flush && empty && (i_valid == '0)) begin
            lat_cur_d = lat_req;
            ack_d     = 1'b1;
          end else begin
            // A concurrent flush is taken first; the load lands next cycle.
            pend_d  = lat_req;
            state_d = LP_DRAIN;
          end
        end
      end
      LP_DRAIN: begin
        if (lat_load) begin
          err_d = 1'b1;
        end
        if (empty || flush) begin
          lat_cur_d = pend_q;
          ack_d     = 1'b1;
          state_d   = LP_IDLE;
        end
      end
      default: begin
        state_d = LP_IDLE;
      end
    endcase
  end

  always_ff @(posedge g.clk) begin
    if (!g.reset_l) begin
      state_q   <= LP_IDLE;
      lat_cur_q <= LW'(DEFAULT_DELAY);
      pend_q    <= LW'(DEFAULT_DELAY);
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      lat_cur_q <= lat_cur_d;
      pend_q    <= pend_d;
      ack_q     <= ack_d;
      err_q     <= err_d;
    end
  end

  assign lat_cur = lat_cur_q;
  assign lat_ack = ack_q;
  assign lat_err = err_q;

endmodule

// File: tb/tb_lat_match_pipe.sv
// Directed bench for lat_match_pipe with a queue scoreboard on the output side.
module tb_lat_match_pipe;

  localparam int WIDTH         = 8;
  localparam int CHANNELS      = 2;
  localparam int MAX_DELAY     = 32;
  localparam int DEFAULT_DELAY = 4;
  localparam int LW            = 6;

  typedef struct {
    int          cnt;
    logic [1:0]  v;
    logic [15:0] d;
    int          lat;
  } sb_t;

  logic        clk = 1'b0;
  logic        reset_l = 1'b0;
  logic        ce, flush, lat_load;
  logic [1:0]  i_valid;
  logic [15:0] i_dat;
  logic [LW-1:0] lat_req;
  logic [1:0]  o_valid;
  logic [15:0] o;
  logic [LW-1:0] lat_cur;
  logic        lat_ack, lat_err, empty;

  int   total = 0;
  int   bad = 0;
  sb_t  sb[$];
  int   ce_cnt = 0;
  logic prev_adv = 1'b0;
  logic hold = 1'b0;
  logic [1:0]  last_ov = 2'b00;
  logic [15:0] last_o = 16'h0;
  logic tb_stall;
  int   lat_model;
  logic got;
  int   n_cyc;
  logic prev_empty;

  always #5 clk = ~clk;

  fixedp_if g_if (.clk(clk), .reset_l(reset_l));

  lat_match_pipe #(
    .WIDTH(WIDTH), .CHANNELS(CHANNELS), .MAX_DELAY(MAX_DELAY), .DEFAULT_DELAY(DEFAULT_DELAY)
  ) dut (
    .g(g_if), .ce(ce), .flush(flush), .i_valid(i_valid), .i(i_dat),
    .lat_load(lat_load), .lat_req(lat_req), .o_valid(o_valid), .o(o),
    .lat_cur(lat_cur), .lat_ack(lat_ack), .lat_err(lat_err), .empty(empty)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic sb_t make_entry(input int cnt, input logic [1:0] v, input logic [15:0] d, input int lat);
    sb_t e;
    e.cnt = cnt;
    e.v   = v;
    e.d   = d & {{8{v[1]}}, {8{v[0]}}};
    e.lat = lat;
    return e;
  endfunction

  // Expected results enter the queue at the edge that accepts a sample.
  always @(posedge clk) begin
    if (!reset_l) begin
      sb.delete();
      ce_cnt   <= 0;
      prev_adv <= 1'b0;
      hold     <= 1'b0;
    end else if (flush) begin
      sb.delete();
      prev_adv <= 1'b0;
      hold     <= 1'b0;
    end else if (ce) begin
      ce_cnt   <= ce_cnt + 1;
      prev_adv <= 1'b1;
      hold     <= 1'b0;
      if (i_valid != 2'b00 && !tb_stall)
        sb.push_back(make_entry(ce_cnt + 1, i_valid, i_dat, lat_model));
    end else begin
      prev_adv <= 1'b0;
      hold     <= 1'b1;
    end
  end

  always @(negedge clk) begin
    if (hold) begin
      chk("stall_hold_ov", {30'd0, o_valid}, {30'd0, last_ov});
      chk("stall_hold_o", {16'd0, o}, {16'd0, last_o});
    end
    if (prev_adv && o_valid != 2'b00) begin
      if (sb.size() == 0) begin
        chk("unexpected_out", {30'd0, o_valid}, 32'd0);
      end else begin
        chk("sb_valid", {30'd0, o_valid}, {30'd0, sb[0].v});
        chk("sb_data", {16'd0, o}, {16'd0, sb[0].d});
        chk("sb_latency", ce_cnt - sb[0].cnt, sb[0].lat - 1);
        sb.delete(0);
      end
    end
    last_ov <= o_valid;
    last_o  <= o;
  end

  task automatic drive(input logic c, input logic f, input logic [1:0] v, input logic [15:0] d,
                       input logic ld, input logic [LW-1:0] lr);
    ce = c; flush = f; i_valid = v; i_dat = d; lat_load = ld; lat_req = lr;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b1, 1'b0, 2'b00, 16'h0, 1'b0, '0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tb_stall = 1'b0;
    lat_model = DEFAULT_DELAY;
    reset_l = 1'b0;
    drive(1'b0, 1'b0, 2'b11, 16'hFFFF, 1'b0, '0);
    drive(1'b1, 1'b0, 2'b11, 16'hFFFF, 1'b1, 6'd7);
    chk("rst_ov", {30'd0, o_valid}, 32'd0);
    chk("rst_o", {16'd0, o}, 32'd0);
    chk("rst_ack", {31'd0, lat_ack}, 32'd0);
    chk("rst_err", {31'd0, lat_err}, 32'd0);
    chk("rst_lat_cur", {26'd0, lat_cur}, DEFAULT_DELAY);
    chk("rst_empty", {31'd0, empty}, 32'd1);
    reset_l = 1'b1;

    // Single sample, default latency 4.
    drive(1'b1, 1'b0, 2'b11, 16'h1234, 1'b0, '0);
    chk("t1_busy", {31'd0, empty}, 32'd0);
    idle(2);
    chk("t1_early", {30'd0, o_valid}, 32'd0);
    idle(1);
    chk("t1_ov", {30'd0, o_valid}, 32'd3);
    chk("t1_o", {16'd0, o}, 32'h1234);
    idle(1);
    chk("t1_ov_gone", {30'd0, o_valid}, 32'd0);
    idle(27);
    chk("t1_tail_busy", {31'd0, empty}, 32'd0);
    idle(1);
    chk("t1_empty", {31'd0, empty}, 32'd1);

    // Stream of 10 with a 3-cycle ce stall; stalled i_valid must be ignored.
    for (int k = 0; k < 10; k++) begin
      if (k == 5) repeat (3) drive(1'b0, 1'b0, 2'b11, 16'hEEEE, 1'b0, '0);
      drive(1'b1, 1'b0, (k % 3 == 0) ? 2'b01 : 2'b11, {8'(8'h40 + k), 8'(8'hA0 + k)}, 1'b0, '0);
    end
    idle(40);
    chk("t2_drained", sb.size(), 32'd0);
    chk("t2_empty", {31'd0, empty}, 32'd1);

    // Idle load of 7, then illegal and boundary loads.
    drive(1'b1, 1'b0, 2'b00, 16'h0, 1'b1, 6'd7);
    chk("t3_ack", {31'd0, lat_ack}, 32'd1);
    chk("t3_lat7", {26'd0, lat_cur}, 32'd7);
    lat_model = 7;
    idle(1);
    chk("t3_ack_pulse", {31'd0, lat_ack}, 32'd0);
    drive(1'b1, 1'b0, 2'b10, 16'hBE00, 1'b0, '0);
    idle(5);
    chk("t3_early", {30'd0, o_valid}, 32'd0);
    idle(1);
    chk("t3_ov", {30'd0, o_valid}, 32'd2);
    chk("t3_o", {16'd0, o}, 32'hBE00);
    idle(40);
    drive(1'b1, 1'b0, 2'b00, 16'h0, 1'b1, 6'd0);
    chk("t3_err_zero", {31'd0, lat_err}, 32'd1);
    chk("t3_noack_zero", {31'd0, lat_ack}, 32'd0);
    chk("t3_keep_zero", {26'd0, lat_cur}, 32'd7);
    drive(1'b1, 1'b0, 2'b00, 16'h0, 1'b1, 6'(MAX_DELAY + 1));
    chk("t3_err_big", {31'd0, lat_err}, 32'd1);
    chk("t3_keep_big", {26'd0, lat_cur}, 32'd7);
    idle(1);
    chk("t3_err_pulse", {31'd0, lat_err}, 32'd0);
    drive(1'b1, 1'b0, 2'b00, 16'h0, 1'b1, 6'(MAX_DELAY));
    chk("t3_ack_max", {31'd0, lat_ack}, 32'd1);
    chk("t3_lat_max", {26'd0, lat_cur}, MAX_DELAY);
    drive(1'b1, 1'b0, 2'b00, 16'h0, 1'b1, 6'd7);
    chk("t3_lat_back", {26'd0, lat_cur}, 32'd7);

    // Load of 2 with three samples in flight: drain, stall, then ack.
    for (int k = 0; k < 3; k++)
      drive(1'b1, 1'b0, 2'b11, {8'(8'hC0 + k), 8'(8'h30 + k)}, 1'b0, '0);
    drive(1'b1, 1'b0, 2'b00, 16'h0, 1'b1, 6'd2);
    chk("t4_pending_ack", {31'd0, lat_ack}, 32'd0);
    chk("t4_pending_lat", {26'd0, lat_cur}, 32'd7);
    tb_stall = 1'b1;
    got = 1'b0;
    n_cyc = 0;
    prev_empty = 1'b0;
    for (int j = 1; j <= 60 && !got; j++) begin
      prev_empty = empty;
      if (j == 5) begin
        drive(1'b1, 1'b0, 2'b11, 16'hDEAD, 1'b1, 6'd9);
        chk("t4_err_in_drain", {31'd0, lat_err}, 32'd1);
      end else begin
        drive(1'b1, 1'b0, 2'b11, 16'hDEAD, 1'b0, '0);
      end
      if (lat_ack) begin
        got = 1'b1;
        n_cyc = j;
      end
    end
    chk("t4_ack_seen", {31'd0, got}, 32'd1);
    chk("t4_drain_cycles", n_cyc, MAX_DELAY);
    chk("t4_empty_before_ack", {31'd0, prev_empty}, 32'd1);
    chk("t4_lat2", {26'd0, lat_cur}, 32'd2);
    tb_stall = 1'b0;
    lat_model = 2;
    drive(1'b1, 1'b0, 2'b01, 16'h0055, 1'b0, '0);
    idle(1);
    chk("t4_post_ov", {30'd0, o_valid}, 32'd1);
    chk("t4_post_o", {16'd0, o}, 32'h0055);
    idle(40);

    // Flush with ce=0 and samples in flight.
    for (int k = 0; k < 5; k++)
      drive(1'b1, 1'b0, 2'b11, {8'(8'h60 + k), 8'(8'h70 + k)}, 1'b0, '0);
    chk("t5_busy", {31'd0, empty}, 32'd0);
    drive(1'b0, 1'b1, 2'b11, 16'hF00D, 1'b0, '0);
    chk("t5_empty", {31'd0, empty}, 32'd1);
    chk("t5_ov", {30'd0, o_valid}, 32'd0);
    for (int k = 0; k < 40; k++) begin
      idle(1);
      chk("t5_quiet", {30'd0, o_valid}, 32'd0);
    end

    // Flush together with a legal load: ack comes one cycle later.
    drive(1'b1, 1'b1, 2'b00, 16'h0, 1'b1, 6'd5);
    chk("t5_fl_noack", {31'd0, lat_ack}, 32'd0);
    chk("t5_fl_lat_old", {26'd0, lat_cur}, 32'd2);
    idle(1);
    chk("t5_fl_ack", {31'd0, lat_ack}, 32'd1);
    chk("t5_fl_lat5", {26'd0, lat_cur}, 32'd5);
    lat_model = 5;

    // Reset while draining with data in flight.
    drive(1'b1, 1'b0, 2'b11, 16'h1111, 1'b0, '0);
    drive(1'b1, 1'b0, 2'b11, 16'h2222, 1'b0, '0);
    drive(1'b1, 1'b0, 2'b00, 16'h0, 1'b1, 6'd3);
    chk("t6_pending", {31'd0, lat_ack}, 32'd0);
    tb_stall = 1'b1;
    idle(2);
    reset_l = 1'b0;
    idle(1);
    reset_l = 1'b1;
    tb_stall = 1'b0;
    lat_model = DEFAULT_DELAY;
    chk("t6_ov", {30'd0, o_valid}, 32'd0);
    chk("t6_o", {16'd0, o}, 32'd0);
    chk("t6_lat_cur", {26'd0, lat_cur}, DEFAULT_DELAY);
    chk("t6_empty", {31'd0, empty}, 32'd1);
    chk("t6_ack", {31'd0, lat_ack}, 32'd0);
    chk("t6_err", {31'd0, lat_err}, 32'd0);
    drive(1'b1, 1'b0, 2'b01, 16'h0077, 1'b0, '0);
    idle(3);
    chk("t6_idle_ov", {30'd0, o_valid}, 32'd1);
    chk("t6_idle_o", {16'd0, o}, 32'h0077);
    idle(40);
    drive(1'b1, 1'b0, 2'b00, 16'h0, 1'b1, 6'd6);
    chk("t6_load_ack", {31'd0, lat_ack}, 32'd1);
    chk("t6_load_lat", {26'd0, lat_cur}, 32'd6);
    idle(2);
    chk("end_sb_empty", sb.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
